// File: rtl/reset_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : reset_seq_pkg
// Brief   : Shared types, default timing constants and helper functions for
//           the sequenced reset controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD  = 3'd0,
      ST_REL   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GAP   = 3'd3,
      ST_UP    = 3'd4,
      ST_FAIL  = 3'd5,
      ST_DRAIN = 3'd6
   } state_t;

   localparam int DEF_HOLD_CYC = 16;
   localparam int DEF_GAP_CYC  = 8;
   localparam int DEF_TO_CYC   = 1024;

   // One counter serves every timed state, so it is sized for the longest.
   function automatic int cnt_w(input int hold, input int gap, input int to);
      int m;
      m = hold;
      if (gap > m) m = gap;
      if (to > m)  m = to;
      return $clog2(m) + 1;
   endfunction

   function automatic int lowest_set(input logic [15:0] v);
      int r;
      r = 0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   function automatic int highest_clr(input logic [15:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 16; i++) begin
         if (!v[i]) r = i;
      end
      return r;
   endfunction

endpackage : reset_seq_pkg

`default_nettype wire

// File: rtl/reset_seq.sv
//------------------------------------------------------------------------------
// Module  : reset_seq
// Brief   : Releases N_STG stage resets in order, waiting for each stage to
//           report ready. Optional RESET_SEQ_REVERSE_ASSERT_EN adds an ordered
//           highest-first re-assert (DRAIN) on soft reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int N_STG    = 4,
   parameter int HOLD_CYC = DEF_HOLD_CYC,
   parameter int GAP_CYC  = DEF_GAP_CYC,
   parameter int TO_CYC   = DEF_TO_CYC
) (
   input  logic                                       dclk,
   input  logic                                       areset_n,
   input  logic                                       sw_rst,
   input  logic [N_STG-1:0]                           stg_ready,
   output logic [N_STG-1:0]                           stg_rst,
   output logic                                       all_up,
   output logic                                       busy,
   output logic                                       err,
   output logic [((N_STG > 1) ? $clog2(N_STG) : 1)-1:0] err_stg
);

   localparam int IDX_W = (N_STG > 1) ? $clog2(N_STG) : 1;
   localparam int CNT_W = cnt_w(HOLD_CYC, GAP_CYC, TO_CYC);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [N_STG-1:0]   r_rst, w_rst_nxt;
   logic [N_STG-1:0]   r_rdy_q;
   logic               r_all_up, w_all_up_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_err, w_err_nxt;
   logic [IDX_W-1:0]   r_err_stg, w_err_stg_nxt;
   logic [15:0]        w_fall_pad;
   logic               w_restart;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
   logic [15:0]        w_rst_pad;
   logic [IDX_W-1:0]   w_hi_idx;
`endif

   always_ff @(posedge dclk or negedge areset_n) begin
      if (!areset_n) begin
         r_state   <= ST_HOLD;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_rst     <= '1;
         r_rdy_q   <= '0;
         r_all_up  <= 1'b0;
         r_busy    <= 1'b1;
         r_err     <= 1'b0;
         r_err_stg <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_rst     <= w_rst_nxt;
         r_rdy_q   <= stg_ready;
         r_all_up  <= w_all_up_nxt;
         r_busy    <= w_busy_nxt;
         r_err     <= w_err_nxt;
         r_err_stg <= w_err_stg_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_rst_nxt     = r_rst;
      w_err_nxt     = r_err;
      w_err_stg_nxt = r_err_stg;
      w_restart     = 1'b0;

      w_fall_pad             = '0;
      w_fall_pad[N_STG-1:0]  = r_rdy_q & ~stg_ready;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      // Unused upper bits read as "still in reset" so they are never picked.
      w_rst_pad              = '1;
      w_rst_pad[N_STG-1:0]   = r_rst;
      w_hi_idx               = IDX_W'(highest_clr(w_rst_pad));
`endif

      case (r_state)
         ST_HOLD: begin
            if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
               w_state_nxt = ST_REL;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_REL: begin
            w_rst_nxt[r_idx] = 1'b0;
            w_cnt_nxt        = '0;
            w_state_nxt      = ST_WAIT;
         end
         ST_WAIT: begin
            if (stg_ready[r_idx]) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (r_idx == IDX_W'(N_STG - 1)) ? ST_UP : ST_GAP;
            end else if (r_cnt == CNT_W'(TO_CYC - 1)) begin
               // The stage that never came up is put back into reset.
               w_state_nxt      = ST_FAIL;
               w_rst_nxt[r_idx] = 1'b1;
               w_err_nxt        = 1'b1;
               w_err_stg_nxt    = r_idx;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_cnt_nxt   = '0;
               w_state_nxt = ST_REL;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_UP: begin
            if ((|w_fall_pad) && !r_err) begin
               w_err_nxt     = 1'b1;
               w_err_stg_nxt = IDX_W'(lowest_set(w_fall_pad));
            end
         end
         ST_FAIL: begin
         end
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
         ST_DRAIN: begin
            if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
               if (&r_rst) begin
                  w_restart = 1'b1;
               end else begin
                  w_rst_nxt[w_hi_idx] = 1'b1;
                  w_cnt_nxt           = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
`endif
         default: begin
            w_restart = 1'b1;
         end
      endcase

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      if (sw_rst && (r_state != ST_DRAIN)) begin
         if (r_state inside {ST_UP, ST_FAIL, ST_WAIT, ST_GAP}) begin
            w_state_nxt   = ST_DRAIN;
            w_cnt_nxt     = '0;
            w_err_nxt     = 1'b0;
            w_err_stg_nxt = '0;
            w_rst_nxt     = r_rst;
            if (!(&r_rst)) w_rst_nxt[w_hi_idx] = 1'b1;
         end else begin
            w_restart = 1'b1;
         end
      end
`else
      if (sw_rst) w_restart = 1'b1;
`endif

      if (w_restart) begin
         w_state_nxt   = ST_HOLD;
         w_cnt_nxt     = '0;
         w_idx_nxt     = '0;
         w_rst_nxt     = '1;
         w_err_nxt     = 1'b0;
         w_err_stg_nxt = '0;
      end

      w_all_up_nxt = (w_state_nxt == ST_UP);
      w_busy_nxt   = (w_state_nxt inside {ST_HOLD, ST_REL, ST_WAIT, ST_GAP, ST_DRAIN});
   end

   assign stg_rst = r_rst;
   assign all_up  = r_all_up;
   assign busy    = r_busy;
   assign err     = r_err;
   assign err_stg = r_err_stg;

endmodule : reset_seq

`default_nettype wire

// File: tb/tb_reset_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_reset_seq
// Brief   : Directed self-checking bench for reset_seq (N_STG=4, HOLD 16,
//           GAP 8, TO 64) with a 3-cycle ready echo of each stage reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reset_seq;

   logic       dclk;
   logic       areset_n;
   logic       sw_rst;
   logic [3:0] stg_ready;
   logic [3:0] stg_rst;
   logic       all_up;
   logic       busy;
   logic       err;
   logic [1:0] err_stg;

   logic [3:0] r_d1, r_d2, r_d3;
   logic [3:0] blk;
   logic [3:0] drop;

   int checks;
   int passes;

   reset_seq #(
      .N_STG    (4),
      .HOLD_CYC (16),
      .GAP_CYC  (8),
      .TO_CYC   (64)
   ) dut (
      .dclk      (dclk),
      .areset_n  (areset_n),
      .sw_rst    (sw_rst),
      .stg_ready (stg_ready),
      .stg_rst   (stg_rst),
      .all_up    (all_up),
      .busy      (busy),
      .err       (err),
      .err_stg   (err_stg)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   // A stage reports ready three cycles after its reset is released.
   always @(posedge dclk or negedge areset_n) begin
      if (!areset_n) begin
         r_d1 <= '0;
         r_d2 <= '0;
         r_d3 <= '0;
      end else begin
         r_d1 <= ~stg_rst;
         r_d2 <= r_d1;
         r_d3 <= r_d2;
      end
   end
   assign stg_ready = r_d3 & ~blk & ~drop;

   task automatic tick;
      @(posedge dclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic restart;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      #3 areset_n = 1'b0;
      #1 areset_n = 1'b1;
`else
      sw_rst = 1'b1;
      tick;
      sw_rst = 1'b0;
`endif
   endtask

   // Called just before edge 1 of a fresh HOLD; checks the full release train.
   task automatic seq_check(input string tag);
      repeat (16) tick;
      chk({tag, "_hold16"}, {28'd0, stg_rst}, 32'hF);
      tick;
      chk({tag, "_rel0"}, {28'd0, stg_rst}, 32'hE);
      repeat (12) tick;
      chk({tag, "_pre1"}, {28'd0, stg_rst}, 32'hE);
      tick;
      chk({tag, "_rel1"}, {28'd0, stg_rst}, 32'hC);
      repeat (13) tick;
      chk({tag, "_rel2"}, {28'd0, stg_rst}, 32'h8);
      repeat (13) tick;
      chk({tag, "_rel3"}, {28'd0, stg_rst}, 32'h0);
      chk({tag, "_busy3"}, {31'd0, busy}, 32'd1);
      repeat (3) tick;
      chk({tag, "_preup"}, {31'd0, all_up}, 32'd0);
      tick;
      chk({tag, "_allup"}, {31'd0, all_up}, 32'd1);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_noerr"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      passes   = 0;
      areset_n = 1'b0;
      sw_rst   = 1'b0;
      blk      = '0;
      drop     = '0;

      repeat (3) tick;
      chk("rst_stg", {28'd0, stg_rst}, 32'hF);
      chk("rst_allup", {31'd0, all_up}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_errstg", {30'd0, err_stg}, 32'd0);
      #4 areset_n = 1'b1;
      seq_check("po");

      // Glitch on stage 1 ready while up: sticky error, no reset action.
      drop = 4'b0010;
      tick;
      drop = 4'b0000;
      chk("drop_err", {31'd0, err}, 32'd1);
      chk("drop_errstg", {30'd0, err_stg}, 32'd1);
      chk("drop_allup", {31'd0, all_up}, 32'd1);
      chk("drop_stg", {28'd0, stg_rst}, 32'h0);
      tick;
      chk("drop_sticky", {31'd0, err}, 32'd1);

`ifndef RESET_SEQ_REVERSE_ASSERT_EN
      sw_rst = 1'b1;
      tick;
      sw_rst = 1'b0;
      chk("swup_stg", {28'd0, stg_rst}, 32'hF);
      chk("swup_allup", {31'd0, all_up}, 32'd0);
      chk("swup_err", {31'd0, err}, 32'd0);
      chk("swup_busy", {31'd0, busy}, 32'd1);
      seq_check("swup");

      restart;
      repeat (31) tick;
      chk("held_wait1", {28'd0, stg_rst}, 32'hC);
      sw_rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("held_stg", {28'd0, stg_rst}, 32'hF);
      end
      sw_rst = 1'b0;
      seq_check("held");
`endif

      // Stage 2 never reports ready: timeout 64 cycles after its release.
      blk = 4'b0100;
      restart;
      repeat (43) tick;
      chk("to_rel2", {28'd0, stg_rst}, 32'h8);
      repeat (63) tick;
      chk("to_early", {31'd0, err}, 32'd0);
      tick;
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_errstg", {30'd0, err_stg}, 32'd2);
      chk("to_stg", {28'd0, stg_rst}, 32'hC);
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_allup", {31'd0, all_up}, 32'd0);
      repeat (20) tick;
      chk("to_halt", {28'd0, stg_rst}, 32'hC);
      blk = 4'b0000;

      // Asynchronous reset landing mid-GAP of stage 0.
      restart;
      repeat (25) tick;
      chk("arst_gap", {28'd0, stg_rst}, 32'hE);
      #2 areset_n = 1'b0;
      #1;
      chk("arst_stg", {28'd0, stg_rst}, 32'hF);
      chk("arst_busy", {31'd0, busy}, 32'd1);
      chk("arst_err", {31'd0, err}, 32'd0);
      #1 areset_n = 1'b1;
      seq_check("arst");

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      sw_rst = 1'b1;
      tick;
      sw_rst = 1'b0;
      chk("drn_first", {28'd0, stg_rst}, 32'h8);
      chk("drn_busy", {31'd0, busy}, 32'd1);
      chk("drn_allup", {31'd0, all_up}, 32'd0);
      repeat (7) tick;
      chk("drn_hold8", {28'd0, stg_rst}, 32'h8);
      tick;
      chk("drn_c", {28'd0, stg_rst}, 32'hC);
      repeat (8) tick;
      chk("drn_e", {28'd0, stg_rst}, 32'hE);
      repeat (8) tick;
      chk("drn_f", {28'd0, stg_rst}, 32'hF);
      repeat (8) tick;
      chk("drn_tohold", {31'd0, busy}, 32'd1);
      seq_check("drn");
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_reset_seq

`default_nettype wire
